gtp_oob_dev: RTL and testbench

- Device-side SATA OOB responder and link-up sequencer, per SATA 2.6 8.4.2. It is the other end of the host OOB initiator and is used for loopback/device emulation on the same V5 GTP tile.
- It waits for COMRESET, answers with COMINIT, then waits for the host COMWAKE and answers with COMWAKE.
- It sends ALIGNp until the host returns ALIGNp, then sends SYNCp and raises link_up.
- After link-up it muxes link-layer dwords onto txdata and inserts ALIGN primitives.

---
 rtl/gtp_oob_dev_if.sv | 8 +
 rtl/gtp_oob_dev.sv | 106 ++++++++++
 tb/tb_gtp_oob_dev.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/gtp_oob_dev_if.sv
// gtp_oob_dev_if: link-layer TX dword stream into the device OOB sequencer
interface gtp_oob_dev_if;
    logic [31:0] txdata_ll;
    logic        txdatak_ll;
    logic        txdatak_pop;
    modport master (output txdata_ll, txdatak_ll, input txdatak_pop);
    modport slave (input txdata_ll, txdatak_ll, output txdatak_pop);
endinterface

// File: rtl/gtp_oob_dev.sv
// gtp_oob_dev: SATA device-side OOB responder and link-up sequencer for the V5 GTP tile
// Define GTP_OOB_DEV_ALIGN_INSERT_EN to insert ALIGNp pairs into the DR_Ready data stream.
module gtp_oob_dev #(
    parameter logic [15:0] C_OOB_DONE_CNT   = 16'h0288,
    parameter logic [15:0] C_TIMEOUT        = 16'hFFFF,
    parameter logic [7:0]  C_ALIGN_INTERVAL = 8'hFF
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        plllkdet,
    input  logic        tx_sync_done,
    input  logic [2:0]  rxstatus,
    input  logic        rxelecidle,
    input  logic        rxbyteisaligned,
    input  logic [31:0] rxdata,
    input  logic [3:0]  rxdatak,
    gtp_oob_dev_if.slave ll,
    output logic        txcomstart,
    output logic        txcomtype,
    output logic        txelecidle,
    output logic [31:0] txdata,
    output logic [3:0]  txdatak,
    output logic        link_up,
    output logic        ComReset,
    output logic [3:0]  state_o
);
    localparam logic [31:0] ALIGNP = 32'h7B4A_4ABC;
    localparam logic [31:0] SYNCP  = 32'hB5B5_957C;
`ifdef GTP_OOB_DEV_ALIGN_INSERT_EN
    localparam logic INS_EN = 1'b1;
`else
    localparam logic INS_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        DR_IDLE, DR_AwaitCOMRESET, DR_AwaitNoCOMRESET, DR_COMINIT, DR_AwaitCOMWAKE,
        DR_AwaitNoCOMWAKE, DR_COMWAKE, DR_SendAlign, DR_Ready
    } st_t;

    st_t         state, nxt;
    logic [15:0] count;
    logic [7:0]  dcnt;
    logic        rdy_q, ins_hold, first, ins, data;
    logic        burst_done, timeout, align_det, cnt_run;

    assign burst_done = count == C_OOB_DONE_CNT || rxstatus[0];
    assign timeout    = count == C_TIMEOUT;
    assign align_det  = rxdata == ALIGNP && rxdatak == 4'h1 && rxbyteisaligned;
    assign first      = state == DR_Ready && !rdy_q;
    // A deferred insertion fires on the first non-K dword once the interval is reached
    assign ins        = INS_EN && state == DR_Ready && !first &&
                        (ins_hold || (dcnt == C_ALIGN_INTERVAL && !ll.txdatak_ll));
    assign data       = state == DR_Ready && !first && !ins;
    assign cnt_run    = nxt == state &&
                        (state inside {DR_COMINIT, DR_AwaitCOMWAKE, DR_COMWAKE, DR_SendAlign});
    assign ll.txdatak_pop = data;
    assign ComReset   = rxstatus[2];
    assign state_o    = state;

    always_comb begin
        nxt = state;
        case (state)
            DR_IDLE:            nxt = plllkdet && tx_sync_done ? DR_AwaitCOMRESET : state;
            DR_AwaitCOMRESET:   nxt = rxstatus[2] ? DR_AwaitNoCOMRESET : state;
            DR_AwaitNoCOMRESET: nxt = !rxstatus[2] ? DR_COMINIT : state;
            DR_COMINIT:         nxt = burst_done ? DR_AwaitCOMWAKE : state;
            DR_AwaitCOMWAKE:    nxt = rxstatus[1] ? DR_AwaitNoCOMWAKE : timeout ? DR_COMINIT : state;
            DR_AwaitNoCOMWAKE:  nxt = !rxstatus[1] ? DR_COMWAKE : state;
            DR_COMWAKE:         nxt = burst_done ? DR_SendAlign : state;
            DR_SendAlign:       nxt = align_det ? DR_Ready : timeout ? DR_AwaitCOMRESET : state;
            DR_Ready:           nxt = rxelecidle ? DR_AwaitCOMRESET : state;
            default:            nxt = DR_IDLE;
        endcase
        if (rxstatus[2] && !(state inside {DR_IDLE, DR_AwaitCOMRESET, DR_AwaitNoCOMRESET}))
            nxt = DR_AwaitNoCOMRESET;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= DR_IDLE;
            count      <= '0;
            dcnt       <= '0;
            rdy_q      <= 1'b0;
            ins_hold   <= 1'b0;
            txelecidle <= 1'b1;
            txcomstart <= 1'b0;
            txcomtype  <= 1'b0;
            link_up    <= 1'b0;
            txdata     <= ALIGNP;
            txdatak    <= 4'h1;
        end else begin
            state      <= nxt;
            count      <= cnt_run ? count + 16'd1 : '0;
            rdy_q      <= state == DR_Ready;
            ins_hold   <= ins && !ins_hold;
            dcnt       <= (state != DR_Ready || ins_hold) ? '0 :
                          (data && dcnt != C_ALIGN_INTERVAL) ? dcnt + 8'd1 : dcnt;
            txelecidle <= !(state == DR_SendAlign || state == DR_Ready);
            txcomstart <= state == DR_COMINIT || state == DR_COMWAKE;
            txcomtype  <= state == DR_COMWAKE;
            link_up    <= nxt == DR_Ready;
            txdata     <= data ? ll.txdata_ll : first ? SYNCP : ALIGNP;
            txdatak    <= data ? {3'b0, ll.txdatak_ll} : 4'h1;
        end
    end
endmodule

// File: tb/tb_gtp_oob_dev.sv
// tb_gtp_oob_dev: directed bring-up, timeout, COMRESET and data-stream checks for gtp_oob_dev
module tb_gtp_oob_dev;
    localparam logic [15:0] TMO    = 16'h0200;
    localparam logic [31:0] ALIGNP = 32'h7B4A_4ABC;
    localparam logic [31:0] SYNCP  = 32'hB5B5_957C;
`ifdef GTP_OOB_DEV_ALIGN_INSERT_EN
    localparam int PER = 257;
    localparam int N   = 600;
`else
    localparam int PER = 0;
    localparam int N   = 20;
`endif

    logic        sys_clk = 1'b0, sys_rst_n = 1'b0;
    logic        plllkdet = 1'b1, tx_sync_done = 1'b1, rxelecidle = 1'b0, rxbyteisaligned = 1'b1;
    logic [2:0]  rxstatus = '0;
    logic [31:0] rxdata = '0, txdata;
    logic [3:0]  rxdatak = 4'h1, txdatak;
    logic        txcomstart, txcomtype, txelecidle, link_up, ComReset;
    logic [3:0]  state_o;
    int          n_cmp = 0, n_err = 0;

    gtp_oob_dev_if ll();

    gtp_oob_dev #(.C_TIMEOUT(TMO)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .plllkdet(plllkdet), .tx_sync_done(tx_sync_done),
        .rxstatus(rxstatus), .rxelecidle(rxelecidle), .rxbyteisaligned(rxbyteisaligned),
        .rxdata(rxdata), .rxdatak(rxdatak), .ll(ll.slave), .txcomstart(txcomstart),
        .txcomtype(txcomtype), .txelecidle(txelecidle), .txdata(txdata), .txdatak(txdatak),
        .link_up(link_up), .ComReset(ComReset), .state_o(state_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic bring_up();
        rxstatus = 3'b100; tick();
        rxstatus = 3'b000; tick();
        rxstatus = 3'b001; tick();
        rxstatus = 3'b010; tick();
        rxstatus = 3'b000; tick();
        rxstatus = 3'b001; tick();
        rxstatus = 3'b000; rxdata = ALIGNP; tick();
        rxdata = '0;
        chk("bringup_state", state_o, 4'd8);
    endtask

    initial begin
        int p, d;
        logic pp;
        logic [31:0] pd;
        ll.txdata_ll = '0;
        ll.txdatak_ll = 1'b0;
        tick(10);
        chk("rst_state", state_o, 4'd0);
        chk("rst_elecidle", txelecidle, 1);
        chk("rst_comstart", txcomstart, 0);
        chk("rst_comtype", txcomtype, 0);
        chk("rst_link", link_up, 0);
        chk("rst_txdata", txdata, ALIGNP);
        chk("rst_txdatak", txdatak, 4'h1);
        chk("rst_pop", ll.txdatak_pop, 0);
        sys_rst_n = 1'b1;
        tick();
        chk("idle_exit", state_o, 4'd1);

        rxstatus = 3'b100; tick();
        chk("await_no_comreset", state_o, 4'd2);
        chk("comreset_level", ComReset, 1);
        tick(3);
        rxstatus = 3'b000; tick();
        chk("cominit_state", state_o, 4'd3);
        chk("cominit_latency", txcomstart, 0);
        tick();
        chk("cominit_start", txcomstart, 1);
        chk("cominit_type", txcomtype, 0);
        rxstatus = 3'b001; tick();
        rxstatus = 3'b000; tick();
        chk("cominit_done", txcomstart, 0);
        chk("await_comwake", state_o, 4'd4);

        rxstatus = 3'b010; tick();
        rxstatus = 3'b000; tick();
        chk("comwake_state", state_o, 4'd6);
        tick();
        chk("comwake_start", txcomstart, 1);
        chk("comwake_type", txcomtype, 1);
        tick(16'h0287);
        chk("burst_cnt_hold", state_o, 4'd6);
        tick();
        chk("burst_cnt_end", state_o, 4'd7);
        chk("sendalign_idle_lag", txelecidle, 1);
        tick();
        chk("sendalign_active", txelecidle, 0);
        chk("sendalign_txdata", txdata, ALIGNP);

        rxdata = ALIGNP; tick();
        rxdata = '0;
        chk("ready_state", state_o, 4'd8);
        chk("ready_link", link_up, 1);
        chk("ready_first_pop", ll.txdatak_pop, 0);
        ll.txdata_ll = 32'h1234_5678; ll.txdatak_ll = 1'b0;
        tick();
        chk("sync_txdata", txdata, SYNCP);
        chk("sync_txdatak", txdatak, 4'h1);
        chk("ready_pop", ll.txdatak_pop, 1);
        tick();
        chk("data0", txdata, 32'h1234_5678);
        chk("data0_k", txdatak, 4'h0);
        ll.txdata_ll = 32'hDEAD_BEEF; ll.txdatak_ll = 1'b1;
        tick();
        chk("data1", txdata, 32'hDEAD_BEEF);
        chk("data1_k", txdatak, 4'h1);
        ll.txdatak_ll = 1'b0;

        rxstatus = 3'b100; tick();
        chk("midop_comreset_state", state_o, 4'd2);
        chk("midop_comreset_link", link_up, 0);
        rxstatus = 3'b000; tick();
        rxstatus = 3'b001; tick();
        rxstatus = 3'b000;
        chk("tmo_wake_entry", state_o, 4'd4);
        tick(TMO);
        chk("tmo_wake_hold", state_o, 4'd4);
        tick();
        chk("tmo_wake_retry", state_o, 4'd3);
        tick();
        chk("tmo_wake_cominit", txcomstart, 1);

        rxstatus = 3'b001; tick();
        rxstatus = 3'b010; tick();
        rxstatus = 3'b000; tick();
        rxstatus = 3'b001; tick();
        rxstatus = 3'b000;
        chk("tmo_align_entry", state_o, 4'd7);
        tick();
        chk("tmo_align_active", txelecidle, 0);
        tick(TMO - 1);
        chk("tmo_align_hold", state_o, 4'd7);
        tick();
        chk("tmo_align_exit", state_o, 4'd1);
        tick();
        chk("tmo_align_idle", txelecidle, 1);

        bring_up();
        chk("stream_first_pop", ll.txdatak_pop, 0);
        ll.txdata_ll = 32'hA000_0000; ll.txdatak_ll = 1'b0;
        tick();
        chk("stream_sync", txdata, SYNCP);
        p = 0; d = 0;
        while (d < N && p < 2000) begin
            ll.txdata_ll = 32'hA000_0000 + d;
            chk("stream_pop", ll.txdatak_pop, (PER == 0) ? 1 : ((p % PER) < 255));
            pp = ll.txdatak_pop;
            pd = ll.txdata_ll;
            if (pp) d++;
            tick();
            p++;
            chk("stream_txdata", txdata, pp ? pd : ALIGNP);
        end
        chk("stream_count", d, N);

        rxelecidle = 1'b1; tick();
        rxelecidle = 1'b0;
        chk("elecidle_state", state_o, 4'd1);
        chk("elecidle_link", link_up, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
